// File: rtl/clkbuf_branch_gate_ctrl_if.sv
// clkbuf_branch_gate_ctrl_if: request/grant bundle between requesters and the branch gate scheduler
interface clkbuf_branch_gate_ctrl_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] REQ;
  logic            FORCE_ON;
  logic            GATE_EN;
  logic [NREQ-1:0] ACK;
  logic            BUSY;
  logic [1:0]      STATE;
  modport master (output REQ, FORCE_ON, input GATE_EN, ACK, BUSY, STATE);
  modport slave  (input REQ, FORCE_ON, output GATE_EN, ACK, BUSY, STATE);
endinterface

// File: rtl/clkbuf_branch_gate_ctrl.sv
// clkbuf_branch_gate_ctrl: sequences one shared clock-gate branch through off/wake/on/hold and grants requesters once the branch clock is stable
module clkbuf_branch_gate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int HOLD_CYC = 8,
  parameter int CW       = 4
) (
  input logic                     CLK,
  input logic                     RESETB,
  clkbuf_branch_gate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, HOLD = 2'd3} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gate_q, gate_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            any;
  always_comb begin
    any     = |bus.REQ | bus.FORCE_ON;
    state_d = state_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    ack_d   = '0;
    case (state_q)
      OFF: begin
        gate_d  = any;
        state_d = any ? WAKE : OFF;
        cnt_d   = any ? CW'(WAKE_CYC - 1) : cnt_q;
      end
      WAKE: begin
        gate_d  = 1'b1;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        state_d = (cnt_q != '0) ? WAKE : ON;
        ack_d   = (cnt_q != '0) ? '0 : bus.REQ;
      end
      ON: begin
        gate_d  = 1'b1;
        state_d = any ? ON : HOLD;
        ack_d   = any ? bus.REQ : '0;
        cnt_d   = any ? cnt_q : CW'(HOLD_CYC - 1);
      end
      HOLD: begin
        // a pending request always beats shutdown, even when cnt has expired
        gate_d  = any || (cnt_q != '0);
        state_d = any ? ON : ((cnt_q != '0) ? HOLD : OFF);
        ack_d   = any ? bus.REQ : '0;
        cnt_d   = (!any && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      end
      default: begin
        state_d = OFF;
        gate_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != OFF);
  end
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.GATE_EN = gate_q;
  assign bus.ACK     = ack_q;
  assign bus.BUSY    = busy_q;
  assign bus.STATE   = state_q;
endmodule

// File: tb/tb_clkbuf_branch_gate_ctrl.sv
// tb_clkbuf_branch_gate_ctrl: directed checks of wake, hold, regrant, async reset and force-on behaviour
module tb_clkbuf_branch_gate_ctrl;
  logic CLK;
  logic RESETB;
  int checks = 0;
  int errors = 0;
  clkbuf_branch_gate_ctrl_if #(.NREQ(4)) bus ();
  clkbuf_branch_gate_ctrl #(.NREQ(4), .WAKE_CYC(2), .HOLD_CYC(8), .CW(4)) dut (
    .CLK   (CLK),
    .RESETB(RESETB),
    .bus   (bus.slave)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic see(input string tag, input logic [1:0] st, input logic g, input logic [3:0] a);
    chk({tag, ".state"}, 32'(bus.STATE), 32'(st));
    chk({tag, ".gate"}, 32'(bus.GATE_EN), 32'(g));
    chk({tag, ".ack"}, 32'(bus.ACK), 32'(a));
    chk({tag, ".busy"}, 32'(bus.BUSY), 32'(st != 2'd0));
  endtask
  initial begin
    RESETB = 1'b0;
    bus.REQ = 4'b1111;
    bus.FORCE_ON = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      see("reset", 2'd0, 1'b0, 4'b0000);
    end
    bus.REQ = 4'b0000;
    RESETB = 1'b1;
    tick();
    see("idle", 2'd0, 1'b0, 4'b0000);
    bus.REQ = 4'b0001;
    tick();
    see("wake_e0", 2'd1, 1'b1, 4'b0000);
    tick();
    see("wake_e1", 2'd1, 1'b1, 4'b0000);
    tick();
    see("wake_e2", 2'd2, 1'b1, 4'b0001);
    bus.REQ = 4'b0011;
    tick();
    see("on_follow", 2'd2, 1'b1, 4'b0011);
    bus.REQ = 4'b0000;
    tick();
    see("hold_e0", 2'd3, 1'b1, 4'b0000);
    for (int i = 1; i < 8; i++) begin
      tick();
      see("hold_n", 2'd3, 1'b1, 4'b0000);
    end
    tick();
    see("hold_e8", 2'd0, 1'b0, 4'b0000);
    bus.REQ = 4'b0100;
    repeat (3) tick();
    see("rg_on", 2'd2, 1'b1, 4'b0100);
    bus.REQ = 4'b0000;
    tick();
    see("rg_hold", 2'd3, 1'b1, 4'b0000);
    repeat (7) begin
      tick();
      chk("rg_gate", 32'(bus.GATE_EN), 32'd1);
    end
    bus.REQ = 4'b0100;
    tick();
    see("rg_regrant", 2'd2, 1'b1, 4'b0100);
    bus.REQ = 4'b0000;
    repeat (9) tick();
    see("rg_off", 2'd0, 1'b0, 4'b0000);
    bus.REQ = 4'b0001;
    tick();
    tick();
    see("mw_e1", 2'd1, 1'b1, 4'b0000);
    #2 RESETB = 1'b0;
    #1;
    see("mw_async", 2'd0, 1'b0, 4'b0000);
    tick();
    see("mw_held", 2'd0, 1'b0, 4'b0000);
    RESETB = 1'b1;
    tick();
    see("mw_r0", 2'd1, 1'b1, 4'b0000);
    tick();
    see("mw_r1", 2'd1, 1'b1, 4'b0000);
    tick();
    see("mw_r2", 2'd2, 1'b1, 4'b0001);
    bus.REQ = 4'b0000;
    repeat (9) tick();
    see("mw_off", 2'd0, 1'b0, 4'b0000);
    bus.FORCE_ON = 1'b1;
    repeat (3) tick();
    see("fo_on", 2'd2, 1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      see("fo_hold", 2'd2, 1'b1, 4'b0000);
    end
    bus.REQ = 4'b1000;
    tick();
    see("fo_req", 2'd2, 1'b1, 4'b1000);
    bus.REQ = 4'b0000;
    tick();
    see("fo_noack", 2'd2, 1'b1, 4'b0000);
    bus.FORCE_ON = 1'b0;
    tick();
    see("fo_drop", 2'd3, 1'b1, 4'b0000);
    repeat (7) tick();
    see("fo_last", 2'd3, 1'b1, 4'b0000);
    tick();
    see("fo_off", 2'd0, 1'b0, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
